// File: rtl/sr_wb_unit.sv
// ============================================================================
// Module   : sr_wb_unit
// Brief    : Writeback/NZP stage with register file, CC register, bypassed
//            decode read ports and busy scoreboard. Optional SR_RETIRE_CNT_EN
//            builds the retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_wb_unit #(
   parameter  int DATA_W   = 16,
   parameter  int NUM_REGS = 8,
   localparam int ID_W     = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sr_v,
   input  logic [3:0]          sr_cs,
   input  logic [DATA_W-1:0]   sr_npc,
   input  logic [DATA_W-1:0]   sr_address,
   input  logic [DATA_W-1:0]   sr_alu_result,
   input  logic [DATA_W-1:0]   sr_data,
   input  logic [ID_W-1:0]     sr_drid,
   output logic                v_sr_ld_reg,
   output logic                v_sr_ld_cc,
   output logic [DATA_W-1:0]   sr_reg_data,
   output logic [2:0]          sr_cc_data,
   input  logic [ID_W-1:0]     rd_a_id,
   output logic [DATA_W-1:0]   rd_a_data,
   input  logic [ID_W-1:0]     rd_b_id,
   output logic [DATA_W-1:0]   rd_b_data,
   output logic [2:0]          cc_q,
   input  logic                sb_set_v,
   input  logic [ID_W-1:0]     sb_set_id,
   output logic [NUM_REGS-1:0] busy,
   output logic [31:0]         retire_cnt
);

   localparam logic [2:0] c_cc_n = 3'b100;
   localparam logic [2:0] c_cc_z = 3'b010;
   localparam logic [2:0] c_cc_p = 3'b001;

   logic                w_ld_cc;
   logic                w_ld_reg;
   logic [1:0]          w_wb_mux;
   logic [DATA_W-1:0]   r_regfile [NUM_REGS];
   logic [2:0]          r_cc;
   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_nxt;

   assign w_ld_cc  = sr_cs[3];
   assign w_ld_reg = sr_cs[2];
   assign w_wb_mux = sr_cs[1:0];

   assign v_sr_ld_reg = sr_v & w_ld_reg;
   assign v_sr_ld_cc  = sr_v & w_ld_cc;

   always_comb begin
      sr_reg_data = sr_address;
      case (w_wb_mux)
         2'b00:   sr_reg_data = sr_address;
         2'b01:   sr_reg_data = sr_data;
         2'b10:   sr_reg_data = sr_npc;
         default: sr_reg_data = sr_alu_result;
      endcase
   end

   always_comb begin
      sr_cc_data = c_cc_p;
      if (sr_reg_data[DATA_W-1])
         sr_cc_data = c_cc_n;
      else if (sr_reg_data == '0)
         sr_cc_data = c_cc_z;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_regfile[i] <= '0;
      end else if (v_sr_ld_reg) begin
         r_regfile[sr_drid] <= sr_reg_data;
      end
   end

   // Write-through bypass lets decode see the retiring value in the same cycle.
   assign rd_a_data = (v_sr_ld_reg && (rd_a_id == sr_drid)) ? sr_reg_data : r_regfile[rd_a_id];
   assign rd_b_data = (v_sr_ld_reg && (rd_b_id == sr_drid)) ? sr_reg_data : r_regfile[rd_b_id];

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_cc <= c_cc_z;
      else if (v_sr_ld_cc)
         r_cc <= sr_cc_data;
   end

   assign cc_q = r_cc;

   // A set and clear of the same register in one cycle means a new producer
   // issued as the old one retired, so the set must win.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      logic w_set;
      logic w_clr;
      assign w_set          = sb_set_v & (sb_set_id == ID_W'(gi));
      assign w_clr          = v_sr_ld_reg & (sr_drid == ID_W'(gi));
      assign w_busy_nxt[gi] = w_set | (r_busy[gi] & ~w_clr);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   assign busy = r_busy;

`ifdef SR_RETIRE_CNT_EN
   logic [31:0] r_retire_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_retire_cnt <= '0;
      else if (sr_v)
         r_retire_cnt <= r_retire_cnt + 32'd1;
   end

   assign retire_cnt = r_retire_cnt;
`else
   assign retire_cnt = 32'h0;
`endif

endmodule

`default_nettype wire
